testdrive_slave_bus_arbiter: RTL and testbench

//  Shares one virtual-slave register port (WE/WADDR/WDATA, RE/RADDR/RDATA) between C_PORTS requesters.

---
 rtl/testdrive_slave_bus_arbiter.sv | 148 ++++++++++++++
 tb/tb_testdrive_slave_bus_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/testdrive_slave_bus_arbiter.sv
// Round-robin arbiter sharing one virtual-slave register port between C_PORTS requesters.
// Grants one transaction per cycle and routes read data back to its owner after the slave latency.
module testdrive_slave_bus_arbiter #(
  parameter int C_PORTS      = 4,
  parameter int C_ADDR_BITS  = 10,
  parameter int C_RD_LATENCY = 1
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic [C_PORTS-1:0]             REQ_WE,
  input  logic [C_PORTS-1:0]             REQ_RE,
  input  logic [C_PORTS*C_ADDR_BITS-1:0] REQ_ADDR,
  input  logic [C_PORTS*32-1:0]          REQ_WDATA,
  output logic [C_PORTS-1:0]             REQ_ACK,
  output logic [C_PORTS-1:0]             REQ_RVALID,
  output logic [31:0]                    REQ_RDATA,
  output logic                           WE,
  output logic [C_ADDR_BITS-1:0]         WADDR,
  output logic [31:0]                    WDATA,
  output logic                           RE,
  output logic [C_ADDR_BITS-1:0]         RADDR,
  input  logic [31:0]                    RDATA
);

  localparam int IW = (C_PORTS > 1) ? $clog2(C_PORTS) : 1;
  typedef logic [IW-1:0] idx_t;

  function automatic idx_t wrap_add(idx_t base, int off);
    int s;
    s = int'(base) + off;
    if (s >= C_PORTS) s = s - C_PORTS;
    return idx_t'(s);
  endfunction

  logic [C_PORTS-1:0]     req;
  logic                   grant_valid;
  idx_t                   grant_idx;
  idx_t                   cand;
  logic                   grant_we;
  logic [C_ADDR_BITS-1:0] grant_addr;
  logic [31:0]            grant_wdata;

  idx_t                   ptr_q,     ptr_d;
  logic                   we_q,      we_d;
  logic                   re_q,      re_d;
  logic [C_ADDR_BITS-1:0] waddr_q,   waddr_d;
  logic [31:0]            wdata_q,   wdata_d;
  logic [C_ADDR_BITS-1:0] raddr_q,   raddr_d;
  idx_t                   rd_port_q, rd_port_d;
  logic [C_PORTS-1:0]     rvalid_q,  rvalid_d;
  logic [31:0]            rdata_q,   rdata_d;

  // Return pipe stage k carries the read issued k+1 cycles earlier; its tail lines up with RDATA.
  logic [C_RD_LATENCY-1:0] pipe_vld_q, pipe_vld_d;
  idx_t                    pipe_idx_q [C_RD_LATENCY];
  idx_t                    pipe_idx_d [C_RD_LATENCY];

  always_comb begin
    // NOTE: every signal gets a default first so no path through this block infers a latch.
    req         = REQ_WE | REQ_RE;
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < C_PORTS; k++) begin
      cand = wrap_add(ptr_q, k);
      if (!grant_valid && req[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end

    REQ_ACK = '0;
    if (grant_valid) REQ_ACK[grant_idx] = 1'b1;

    // A port raising both strobes is served as a write; its read stays pending.
    grant_we    = REQ_WE[grant_idx];
    grant_addr  = REQ_ADDR[grant_idx*C_ADDR_BITS +: C_ADDR_BITS];
    grant_wdata = REQ_WDATA[grant_idx*32 +: 32];

    ptr_d     = grant_valid ? wrap_add(grant_idx, 1) : ptr_q;
    we_d      = grant_valid & grant_we;
    re_d      = grant_valid & ~grant_we;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    raddr_d   = raddr_q;
    rd_port_d = rd_port_q;
    if (we_d) begin
      waddr_d = grant_addr;
      wdata_d = grant_wdata;
    end
    if (re_d) begin
      raddr_d   = grant_addr;
      rd_port_d = grant_idx;
    end

    pipe_vld_d[0] = re_q;
    pipe_idx_d[0] = rd_port_q;
    for (int k = 1; k < C_RD_LATENCY; k++) begin
      pipe_vld_d[k] = pipe_vld_q[k-1];
      pipe_idx_d[k] = pipe_idx_q[k-1];
    end

    rvalid_d = '0;
    rdata_d  = rdata_q;
    if (pipe_vld_q[C_RD_LATENCY-1]) begin
      rvalid_d[pipe_idx_q[C_RD_LATENCY-1]] = 1'b1;
      rdata_d = RDATA;
    end
  end

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ptr_q      <= '0;
      we_q       <= 1'b0;
      re_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      raddr_q    <= '0;
      rd_port_q  <= '0;
      rvalid_q   <= '0;
      rdata_q    <= '0;
      pipe_vld_q <= '0;
      for (int k = 0; k < C_RD_LATENCY; k++) pipe_idx_q[k] <= '0;
    end else begin
      ptr_q      <= ptr_d;
      we_q       <= we_d;
      re_q       <= re_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      raddr_q    <= raddr_d;
      rd_port_q  <= rd_port_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      pipe_vld_q <= pipe_vld_d;
      for (int k = 0; k < C_RD_LATENCY; k++) pipe_idx_q[k] <= pipe_idx_d[k];
    end
  end

  assign WE         = we_q;
  assign WADDR      = waddr_q;
  assign WDATA      = wdata_q;
  assign RE         = re_q;
  assign RADDR      = raddr_q;
  assign REQ_RVALID = rvalid_q;
  assign REQ_RDATA  = rdata_q;

endmodule

// File: tb/tb_testdrive_slave_bus_arbiter.sv
// Directed bench: a latency-1 arbiter with a memory slave, and a latency-3 arbiter
// whose slave returns an address-tagged constant.
module tb_testdrive_slave_bus_arbiter;

  localparam int NP = 4;
  localparam int AW = 10;

  logic clk;
  logic rst;

  // Latency-1 instance
  logic [NP-1:0]    we1, re1, ack1, rvalid1;
  logic [NP*AW-1:0] addr1;
  logic [NP*32-1:0] wdata1;
  logic [31:0]      rdata_out1, s_wdata1, s_rdata1;
  logic             s_we1, s_re1;
  logic [AW-1:0]    s_waddr1, s_raddr1;

  // Latency-3 instance
  logic [NP-1:0]    we3, re3, ack3, rvalid3;
  logic [NP*AW-1:0] addr3;
  logic [NP*32-1:0] wdata3;
  logic [31:0]      rdata_out3, s_wdata3, s_rdata3;
  logic             s_we3, s_re3;
  logic [AW-1:0]    s_waddr3, s_raddr3;

  int passes = 0;
  int total  = 0;

  testdrive_slave_bus_arbiter #(.C_PORTS(NP), .C_ADDR_BITS(AW), .C_RD_LATENCY(1)) dut1 (
    .CLK(clk), .RST(rst),
    .REQ_WE(we1), .REQ_RE(re1), .REQ_ADDR(addr1), .REQ_WDATA(wdata1),
    .REQ_ACK(ack1), .REQ_RVALID(rvalid1), .REQ_RDATA(rdata_out1),
    .WE(s_we1), .WADDR(s_waddr1), .WDATA(s_wdata1),
    .RE(s_re1), .RADDR(s_raddr1), .RDATA(s_rdata1)
  );

  testdrive_slave_bus_arbiter #(.C_PORTS(NP), .C_ADDR_BITS(AW), .C_RD_LATENCY(3)) dut3 (
    .CLK(clk), .RST(rst),
    .REQ_WE(we3), .REQ_RE(re3), .REQ_ADDR(addr3), .REQ_WDATA(wdata3),
    .REQ_ACK(ack3), .REQ_RVALID(rvalid3), .REQ_RDATA(rdata_out3),
    .WE(s_we3), .WADDR(s_waddr3), .WDATA(s_wdata3),
    .RE(s_re3), .RADDR(s_raddr3), .RDATA(s_rdata3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave 1: register file, read data one cycle after RE.
  logic [31:0] mem1 [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (s_we1) mem1[s_waddr1] <= s_wdata1;
    if (s_re1) s_rdata1 <= mem1[s_raddr1];
  end

  // Slave 3: returns C0DE0000|addr three cycles after RE.
  logic [31:0] sp0, sp1;
  always @(posedge clk) begin
    sp0      <= 32'hC0DE_0000 | 32'(s_raddr3);
    sp1      <= sp0;
    s_rdata3 <= sp1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req1(input int p, input logic w, input logic r,
                      input logic [AW-1:0] a, input logic [31:0] d);
    we1[p] = w;
    re1[p] = r;
    addr1[p*AW +: AW] = a;
    wdata1[p*32 +: 32] = d;
  endtask

  task automatic req3(input int p, input logic r, input logic [AW-1:0] a);
    we3[p] = 1'b0;
    re3[p] = r;
    addr3[p*AW +: AW] = a;
  endtask

  initial begin
    we1 = '0; re1 = '0; addr1 = '0; wdata1 = '0;
    we3 = '0; re3 = '0; addr3 = '0; wdata3 = '0;
    rst = 1'b1;

    // 1. Reset with every port requesting a write.
    for (int i = 0; i < NP; i++) req1(i, 1'b1, 1'b0, AW'(i), 32'hA0 + 32'(i));
    step();
    step();
    #1;
    check("rst_we", 32'(s_we1), 32'h0);
    check("rst_re", 32'(s_re1), 32'h0);
    check("rst_rvalid", 32'(rvalid1), 32'h0);
    check("rst_waddr", 32'(s_waddr1), 32'h0);
    rst = 1'b0;
    #1;

    // 2. Round-robin over four writers.
    for (int i = 0; i < NP; i++) begin
      check($sformatf("wr_ack%0d", i), 32'(ack1), 32'(1 << i));
      if (i > 0) begin
        check($sformatf("wr_we%0d", i), 32'(s_we1), 32'h1);
        check($sformatf("wr_waddr%0d", i), 32'(s_waddr1), 32'(i - 1));
        check($sformatf("wr_wdata%0d", i), s_wdata1, 32'hA0 + 32'(i - 1));
      end
      step();
      req1(i, 1'b0, 1'b0, AW'(i), 32'hA0 + 32'(i));
      #1;
    end
    check("wr_ack_idle", 32'(ack1), 32'h0);
    check("wr_we_last", 32'(s_we1), 32'h1);
    check("wr_waddr_last", 32'(s_waddr1), 32'h3);
    check("wr_wdata_last", s_wdata1, 32'hA3);
    step();
    check("wr_we_off", 32'(s_we1), 32'h0);
    check("wr_waddr_hold", 32'(s_waddr1), 32'h3);

    // 3. Port 0 writes DEADBEEF to 3F, port 2 reads it back.
    req1(0, 1'b1, 1'b0, 10'h3F, 32'hDEAD_BEEF);
    #1;
    check("rd_wr_ack", 32'(ack1), 32'h1);
    step();
    req1(0, 1'b0, 1'b0, 10'h3F, 32'hDEAD_BEEF);
    req1(2, 1'b0, 1'b1, 10'h3F, 32'h0);
    #1;
    check("rd_ack", 32'(ack1), 32'h4);
    check("rd_we_pre", 32'(s_we1), 32'h1);
    step();
    req1(2, 1'b0, 1'b0, 10'h3F, 32'h0);
    #1;
    check("rd_re", 32'(s_re1), 32'h1);
    check("rd_raddr", 32'(s_raddr1), 32'h3F);
    check("rd_we_off", 32'(s_we1), 32'h0);
    step();
    check("rd_rvalid_early", 32'(rvalid1), 32'h0);
    step();
    check("rd_rvalid", 32'(rvalid1), 32'h4);
    check("rd_rdata", rdata_out1, 32'hDEAD_BEEF);
    step();
    check("rd_rvalid_pulse", 32'(rvalid1), 32'h0);

    // 4. Port 1 raises WE and RE together: write first, then read returns it.
    req1(1, 1'b1, 1'b1, 10'h005, 32'h7);
    #1;
    check("wr_rd_ack_w", 32'(ack1), 32'h2);
    step();
    req1(1, 1'b0, 1'b1, 10'h005, 32'h7);
    #1;
    check("wr_rd_we", 32'(s_we1), 32'h1);
    check("wr_rd_re_not_yet", 32'(s_re1), 32'h0);
    check("wr_rd_waddr", 32'(s_waddr1), 32'h5);
    check("wr_rd_ack_r", 32'(ack1), 32'h2);
    step();
    req1(1, 1'b0, 1'b0, 10'h005, 32'h7);
    #1;
    check("wr_rd_re", 32'(s_re1), 32'h1);
    step();
    step();
    check("wr_rd_rvalid", 32'(rvalid1), 32'h2);
    check("wr_rd_rdata", rdata_out1, 32'h7);

    // 5. Latency 3: back-to-back reads from ports 0, 1, 3.
    req3(0, 1'b1, 10'h010);
    req3(1, 1'b1, 10'h011);
    req3(3, 1'b1, 10'h013);
    #1;
    check("l3_ack0", 32'(ack3), 32'h1);
    step();
    req3(0, 1'b0, 10'h010);
    #1;
    check("l3_ack1", 32'(ack3), 32'h2);
    step();
    req3(1, 1'b0, 10'h011);
    #1;
    check("l3_ack3", 32'(ack3), 32'h8);
    step();
    req3(3, 1'b0, 10'h013);
    step();
    check("l3_rvalid_early", 32'(rvalid3), 32'h0);
    step();
    check("l3_rvalid0", 32'(rvalid3), 32'h1);
    check("l3_rdata0", rdata_out3, 32'hC0DE_0010);
    step();
    check("l3_rvalid1", 32'(rvalid3), 32'h2);
    check("l3_rdata1", rdata_out3, 32'hC0DE_0011);
    step();
    check("l3_rvalid3", 32'(rvalid3), 32'h8);
    check("l3_rdata3", rdata_out3, 32'hC0DE_0013);
    step();
    check("l3_rvalid_done", 32'(rvalid3), 32'h0);

    // 6. Reset while a read is in flight; pointer returns to 0.
    req1(1, 1'b0, 1'b1, 10'h005, 32'h0);
    #1;
    check("rst_rd_ack", 32'(ack1), 32'h2);
    step();
    req1(1, 1'b0, 1'b0, 10'h005, 32'h0);
    #1;
    check("rst_rd_re", 32'(s_re1), 32'h1);
    step();
    rst = 1'b1;
    #1;
    check("rst_mid_re", 32'(s_re1), 32'h0);
    check("rst_mid_rvalid", 32'(rvalid1), 32'h0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("rst_no_rvalid%0d", i), 32'(rvalid1), 32'h0);
    end
    req1(0, 1'b1, 1'b0, 10'h001, 32'h1);
    req1(2, 1'b1, 1'b0, 10'h002, 32'h2);
    #1;
    check("rst_ptr0", 32'(ack1), 32'h1);
    step();
    req1(0, 1'b0, 1'b0, 10'h001, 32'h1);
    #1;
    check("rst_ptr_next", 32'(ack1), 32'h4);
    step();
    req1(2, 1'b0, 1'b0, 10'h002, 32'h2);
    step();

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
